// File: rtl/altpcierd_msi_pkg.sv
// altpcierd_msi_pkg: MSI stream field positions and sink FSM states shared by source and sink.
package altpcierd_msi_pkg;
    localparam int MSI_TC_MSB  = 7;
    localparam int MSI_TC_LSB  = 5;
    localparam int MSI_NUM_MSB = 4;
    localparam int MSI_NUM_LSB = 0;
    typedef enum logic [1:0] {IDLE, REQ, GAP} msi_state_e;
endpackage

// File: rtl/altpcierd_msi_fifo.sv
// altpcierd_msi_fifo: small synchronous FIFO with a separately tracked occupancy count.
module altpcierd_msi_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    assign dout = mem[rd_ptr];
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/altpcierd_cdma_ast_msi_sink.sv
// altpcierd_cdma_ast_msi_sink: buffers MSI stream beats and replays them as req/ack handshakes.
module altpcierd_cdma_ast_msi_sink
    import altpcierd_msi_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int READY_SLACK = 2,
    parameter int CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [7:0]       stream_data,
    input  logic             stream_valid,
    output logic             stream_ready,
    output logic             app_msi_req,
    input  logic             app_msi_ack,
    output logic [2:0]       app_msi_tc,
    output logic [4:0]       app_msi_num,
    output logic [CNT_W-1:0] msi_pending,
    output logic             msi_overflow
);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] READY_LIM = CNT_W'(FIFO_DEPTH - READY_SLACK);
    msi_state_e state;
    logic [7:0] head;
    logic [CNT_W-1:0] count, count_next;
    logic push, pop;
    // A pop frees the slot being written, so a full FIFO still accepts a beat on a pop cycle.
    assign pop  = (count != '0) && (state != REQ);
    assign push = stream_valid && ((count < FULL_CNT) || pop);
    assign msi_pending = count;
    altpcierd_msi_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8), .CNT_W(CNT_W)) u_fifo (
        .clk        (clk_in),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .din        (stream_data),
        .dout       (head),
        .count      (count),
        .count_next (count_next)
    );
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            app_msi_req  <= 1'b0;
            app_msi_tc   <= '0;
            app_msi_num  <= '0;
            stream_ready <= 1'b0;
            msi_overflow <= 1'b0;
        end else begin
            stream_ready <= count_next < READY_LIM;
            if (stream_valid && !push) msi_overflow <= 1'b1;
            case (state)
                IDLE, GAP: begin
                    app_msi_req <= pop;
                    state       <= pop ? REQ : IDLE;
                    if (pop) begin
                        app_msi_tc  <= head[MSI_TC_MSB:MSI_TC_LSB];
                        app_msi_num <= head[MSI_NUM_MSB:MSI_NUM_LSB];
                    end
                end
                REQ: if (app_msi_ack) begin
                    app_msi_req <= 1'b0;
                    state       <= GAP;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_altpcierd_cdma_ast_msi_sink.sv
// tb_altpcierd_cdma_ast_msi_sink: directed scenario tests for the MSI stream sink.
module tb_altpcierd_cdma_ast_msi_sink;
    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] stream_data = '0;
    logic       stream_valid = 1'b0;
    logic       stream_ready;
    logic       app_msi_req;
    logic       app_msi_ack = 1'b0;
    logic [2:0] app_msi_tc;
    logic [4:0] app_msi_num;
    logic [2:0] msi_pending;
    logic       msi_overflow;
    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] vals [6] = '{8'h21, 8'h42, 8'h63, 8'h84, 8'hA5, 8'hC6};

    altpcierd_cdma_ast_msi_sink #(.FIFO_DEPTH(4), .READY_SLACK(2)) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .stream_data  (stream_data),
        .stream_valid (stream_valid),
        .stream_ready (stream_ready),
        .app_msi_req  (app_msi_req),
        .app_msi_ack  (app_msi_ack),
        .app_msi_tc   (app_msi_tc),
        .app_msi_num  (app_msi_num),
        .msi_pending  (msi_pending),
        .msi_overflow (msi_overflow)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        stream_valid = 1'b0;
        app_msi_ack  = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Sends vals[0..n-1] on consecutive cycles; the first beat is in flight when it returns.
    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            stream_data  = vals[i];
            stream_valid = 1'b1;
            tick();
        end
        stream_valid = 1'b0;
    endtask

    task automatic drain(input int n, input int first);
        for (int k = 0; k < n; k++) begin
            int w;
            w = 0;
            while (app_msi_req !== 1'b1 && w < 10) begin
                tick();
                w++;
            end
            n_cmp++;
            if (app_msi_req !== 1'b1 || {app_msi_tc, app_msi_num} !== vals[first+k]) begin
                n_err++;
                $display("FAIL drain[%0d]: req=%b tc/num=%h, want req=1 %h", k, app_msi_req,
                         {app_msi_tc, app_msi_num}, vals[first+k]);
            end
            app_msi_ack = 1'b1;
            tick();
            app_msi_ack = 1'b0;
            n_cmp++;
            if (app_msi_req !== 1'b0) begin
                n_err++;
                $display("FAIL drain_gap[%0d]: req=%b, want 0", k, app_msi_req);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({stream_ready, app_msi_req, app_msi_tc, app_msi_num, msi_pending, msi_overflow} !== '0) begin
            n_err++;
            $display("FAIL reset_vals: rdy=%b req=%b tc=%h num=%h pend=%0d ovf=%b, want all 0",
                     stream_ready, app_msi_req, app_msi_tc, app_msi_num, msi_pending, msi_overflow);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (stream_ready !== 1'b1 || app_msi_req !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: rdy=%b req=%b, want rdy=1 req=0", stream_ready, app_msi_req);
        end
    endtask

    task automatic test_single();
        stream_data  = 8'hA5;
        stream_valid = 1'b1;
        tick();
        stream_valid = 1'b0;
        n_cmp++;
        if (app_msi_req !== 1'b0 || msi_pending !== 3'd1) begin
            n_err++;
            $display("FAIL single_n1: req=%b pend=%0d, want req=0 pend=1", app_msi_req, msi_pending);
        end
        tick();
        n_cmp++;
        if (app_msi_req !== 1'b1 || app_msi_tc !== 3'd5 || app_msi_num !== 5'h05 || msi_pending !== 3'd0) begin
            n_err++;
            $display("FAIL single_req: req=%b tc=%0d num=%h pend=%0d, want 1 5 05 0",
                     app_msi_req, app_msi_tc, app_msi_num, msi_pending);
        end
        app_msi_ack = 1'b1;
        tick();
        app_msi_ack = 1'b0;
        n_cmp++;
        if (app_msi_req !== 1'b0 || msi_pending !== 3'd0) begin
            n_err++;
            $display("FAIL single_ack: req=%b pend=%0d, want 0 0", app_msi_req, msi_pending);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic       exp_req  [9] = '{0, 0, 1, 0, 1, 0, 1, 0, 0};
        logic [2:0] exp_pend [9] = '{0, 1, 1, 2, 1, 1, 0, 0, 0};
        logic [7:0] exp_msg  [9] = '{0, 0, 8'h01, 0, 8'h22, 0, 8'h43, 0, 0};
        logic [7:0] beats    [3] = '{8'h01, 8'h22, 8'h43};
        for (int k = 0; k < 9; k++) begin
            n_cmp++;
            if (app_msi_req !== exp_req[k] || msi_pending !== exp_pend[k] ||
                (exp_req[k] && {app_msi_tc, app_msi_num} !== exp_msg[k])) begin
                n_err++;
                $display("FAIL b2b_c%0d: req=%b pend=%0d tc/num=%h, want req=%b pend=%0d tc/num=%h", k,
                         app_msi_req, msi_pending, {app_msi_tc, app_msi_num}, exp_req[k], exp_pend[k], exp_msg[k]);
            end
            stream_valid = k < 3;
            stream_data  = (k < 3) ? beats[k] : 8'h00;
            app_msi_ack  = exp_req[k];
            tick();
        end
        stream_valid = 1'b0;
        app_msi_ack  = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        fill(2);
        n_cmp++;
        if (stream_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_ready_hi: rdy=%b, want 1", stream_ready);
        end
        fill(0);
        stream_data = vals[2];
        stream_valid = 1'b1;
        tick();
        n_cmp++;
        if (stream_ready !== 1'b0 || msi_pending !== 3'd2) begin
            n_err++;
            $display("FAIL ovf_ready_lo: rdy=%b pend=%0d, want 0 2", stream_ready, msi_pending);
        end
        stream_data = vals[3];
        tick();
        stream_data = vals[4];
        tick();
        n_cmp++;
        if (msi_pending !== 3'd4 || msi_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_full: pend=%0d ovf=%b, want 4 0", msi_pending, msi_overflow);
        end
        stream_data = vals[5];
        tick();
        stream_valid = 1'b0;
        n_cmp++;
        if (msi_pending !== 3'd4 || msi_overflow !== 1'b1 || {app_msi_tc, app_msi_num} !== vals[0]) begin
            n_err++;
            $display("FAIL ovf_drop: pend=%0d ovf=%b tc/num=%h, want 4 1 %h", msi_pending, msi_overflow,
                     {app_msi_tc, app_msi_num}, vals[0]);
        end
        drain(5, 0);
        tick();
        n_cmp++;
        if (app_msi_req !== 1'b0 || msi_pending !== 3'd0 || msi_overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_sticky: req=%b pend=%0d ovf=%b, want 0 0 1", app_msi_req, msi_pending, msi_overflow);
        end
    endtask

    task automatic test_push_pop_full();
        do_reset();
        fill(5);
        n_cmp++;
        if (msi_pending !== 3'd4 || app_msi_req !== 1'b1 || stream_ready !== 1'b0) begin
            n_err++;
            $display("FAIL ppf_full: pend=%0d req=%b rdy=%b, want 4 1 0", msi_pending, app_msi_req, stream_ready);
        end
        app_msi_ack = 1'b1;
        tick();
        app_msi_ack  = 1'b0;
        stream_data  = vals[5];
        stream_valid = 1'b1;
        tick();
        stream_valid = 1'b0;
        n_cmp++;
        if (msi_pending !== 3'd4 || msi_overflow !== 1'b0 || app_msi_req !== 1'b1 ||
            {app_msi_tc, app_msi_num} !== vals[1]) begin
            n_err++;
            $display("FAIL ppf_same: pend=%0d ovf=%b req=%b tc/num=%h, want 4 0 1 %h", msi_pending,
                     msi_overflow, app_msi_req, {app_msi_tc, app_msi_num}, vals[1]);
        end
        drain(5, 1);
    endtask

    task automatic test_spurious_ack();
        do_reset();
        app_msi_ack = 1'b1;
        tick();
        tick();
        app_msi_ack = 1'b0;
        n_cmp++;
        if (app_msi_req !== 1'b0 || msi_pending !== 3'd0) begin
            n_err++;
            $display("FAIL spur_idle: req=%b pend=%0d, want 0 0", app_msi_req, msi_pending);
        end
        fill(2);
        app_msi_ack = 1'b1;
        tick();
        n_cmp++;
        if (app_msi_req !== 1'b0 || msi_pending !== 3'd1) begin
            n_err++;
            $display("FAIL spur_gap_in: req=%b pend=%0d, want 0 1", app_msi_req, msi_pending);
        end
        tick();
        app_msi_ack = 1'b0;
        tick();
        n_cmp++;
        if (app_msi_req !== 1'b1 || msi_pending !== 3'd0 || {app_msi_tc, app_msi_num} !== vals[1]) begin
            n_err++;
            $display("FAIL spur_gap: req=%b pend=%0d tc/num=%h, want 1 0 %h", app_msi_req, msi_pending,
                     {app_msi_tc, app_msi_num}, vals[1]);
        end
        drain(1, 1);
    endtask

    task automatic test_reset_mid_req();
        do_reset();
        fill(4);
        n_cmp++;
        if (app_msi_req !== 1'b1 || msi_pending !== 3'd3) begin
            n_err++;
            $display("FAIL rmid_pre: req=%b pend=%0d, want 1 3", app_msi_req, msi_pending);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({stream_ready, app_msi_req, app_msi_tc, app_msi_num, msi_pending, msi_overflow} !== '0) begin
            n_err++;
            $display("FAIL rmid_async: rdy=%b req=%b tc=%h num=%h pend=%0d ovf=%b, want all 0",
                     stream_ready, app_msi_req, app_msi_tc, app_msi_num, msi_pending, msi_overflow);
        end
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (stream_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rmid_ready: rdy=%b, want 1", stream_ready);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (app_msi_req !== 1'b0 || msi_pending !== 3'd0) begin
                n_err++;
                $display("FAIL rmid_quiet[%0d]: req=%b pend=%0d, want 0 0", k, app_msi_req, msi_pending);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_push_pop_full();
        test_spurious_ack();
        test_reset_mid_req();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
